// File: rtl/data_cache.sv
// data_cache: shared L1 data cache between NUM_CONSUMERS LSU lanes and the
// global memory controller. Set-associative, write-through, no-write-allocate,
// one word per line. Each consumer lane i has a private FSM that talks to
// controller lane i. Lookups and fills arbitrate per bank (bank = set % NUM_BANKS),
// lowest lane index first.
// Ports (all per-lane vectors/arrays indexed by lane):
//   clk, reset (async, active-low)
//   consumer_read_*   : valid/address in, ready/data out
//   consumer_write_*  : valid/address/data in, ready out
//   controller_read_* : valid/address out, ready/data in (miss fetch)
//   controller_write_*: valid/address/data out, ready in (write-through)
module data_cache #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int NUM_CONSUMERS    = 8,
  parameter int NUM_CHANNELS     = 8,
  parameter int NUM_BLOCKS       = 8,
  parameter int NUM_BANKS        = 2,
  parameter int NUM_WAYS         = 4,
  parameter int CACHE_BLOCK_SIZE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data       [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address   [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data      [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CONSUMERS-1:0] controller_read_valid,
  output logic [ADDR_BITS-1:0]     controller_read_address  [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] controller_read_ready,
  input  logic [DATA_BITS-1:0]     controller_read_data     [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] controller_write_valid,
  output logic [ADDR_BITS-1:0]     controller_write_address [NUM_CONSUMERS],
  output logic [DATA_BITS-1:0]     controller_write_data    [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] controller_write_ready
);

  localparam int SETS      = NUM_BLOCKS / NUM_WAYS;
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_BITS  = ADDR_BITS - SET_BITS;
  localparam int WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // Unsupported geometries stop elaboration rather than building a broken cache.
  if (CACHE_BLOCK_SIZE != 1 || NUM_CHANNELS < 1 || SETS < 2 ||
      (NUM_BLOCKS % NUM_WAYS) != 0 || (SETS % NUM_BANKS) != 0) begin : g_bad_cfg
    $error("data_cache: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_READ, S_FILL, S_MEM_WRITE, S_DONE
  } state_t;

  // Cache arrays, organised by set; a set's bank is set % NUM_BANKS.
  logic [TAG_BITS-1:0]  r_tag   [SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] r_data  [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  r_valid [SETS];
  logic [WAY_BITS-1:0]  r_rr    [SETS];

  // Per-lane request/update signals gathered for arbitration and array writes.
  logic [NUM_CONSUMERS-1:0] w_req;
  logic [NUM_CONSUMERS-1:0] w_grant;
  logic [NUM_CONSUMERS-1:0] w_wr_hit_en;
  logic [NUM_CONSUMERS-1:0] w_fill_en;
  logic [NUM_CONSUMERS-1:0] w_lane_use_rr;
  logic [BANK_BITS-1:0]     w_bank      [NUM_CONSUMERS];
  logic [SET_BITS-1:0]      w_lane_set  [NUM_CONSUMERS];
  logic [TAG_BITS-1:0]      w_lane_tag  [NUM_CONSUMERS];
  logic [WAY_BITS-1:0]      w_lane_way  [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     w_lane_data [NUM_CONSUMERS];

  // Fixed-priority grant per bank: a lane is granted unless a lower lane wants the same bank.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      w_grant[i] = w_req[i];
      for (int j = 0; j < i; j++) begin
        if (w_req[j] && (w_bank[j] == w_bank[i])) w_grant[i] = 1'b0;
      end
    end
  end

  // Tag/data storage; at most one granted lane per bank writes in a cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (w_wr_hit_en[i]) begin
        r_data[w_lane_set[i]][w_lane_way[i]] <= w_lane_data[i];
      end else if (w_fill_en[i]) begin
        r_tag[w_lane_set[i]][w_lane_way[i]]  <= w_lane_tag[i];
        r_data[w_lane_set[i]][w_lane_way[i]] <= w_lane_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (w_fill_en[i]) begin
          r_valid[w_lane_set[i]][w_lane_way[i]] <= 1'b1;
          // The pointer only advances when it actually chose the victim.
          if (w_lane_use_rr[i]) begin
            r_rr[w_lane_set[i]] <= (r_rr[w_lane_set[i]] == WAY_BITS'(NUM_WAYS - 1)) ?
                                   '0 : r_rr[w_lane_set[i]] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_lane
    state_t               r_state, w_state_next;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata, r_rdata;
    logic                 r_is_write;
    logic [SET_BITS-1:0]  w_set;
    logic [TAG_BITS-1:0]  w_tag;
    logic                 w_hit, w_use_rr;
    logic [WAY_BITS-1:0]  w_hit_way, w_victim;
    logic                 w_rd_ready, w_wr_ready, w_ctl_rv, w_ctl_wv;
    logic [DATA_BITS-1:0] w_rd_data, w_ctl_wdata;
    logic [ADDR_BITS-1:0] w_ctl_raddr, w_ctl_waddr;

    assign w_set = r_addr[SET_BITS-1:0];
    assign w_tag = r_addr[ADDR_BITS-1:SET_BITS];

    // Hit search and victim choice (lowest matching / lowest invalid way).
    always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_victim  = r_rr[w_set];
      w_use_rr  = 1'b1;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
          w_hit     = 1'b1;
          w_hit_way = WAY_BITS'(w);
        end
        if (!r_valid[w_set][w]) begin
          w_victim = WAY_BITS'(w);
          w_use_rr = 1'b0;
        end
      end
    end

    assign w_req[gi]         = (r_state == S_LOOKUP) || (r_state == S_FILL);
    assign w_bank[gi]        = BANK_BITS'(32'(w_set) % NUM_BANKS);
    assign w_wr_hit_en[gi]   = (r_state == S_LOOKUP) && w_grant[gi] && r_is_write && w_hit;
    assign w_fill_en[gi]     = (r_state == S_FILL) && w_grant[gi];
    assign w_lane_use_rr[gi] = w_use_rr;
    assign w_lane_set[gi]    = w_set;
    assign w_lane_tag[gi]    = w_tag;
    assign w_lane_way[gi]    = (r_state == S_FILL) ? w_victim : w_hit_way;
    assign w_lane_data[gi]   = r_is_write ? r_wdata : r_rdata;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
      w_state_next = r_state;
      case (r_state)
        S_IDLE: begin
          if (consumer_read_valid[gi] || consumer_write_valid[gi]) w_state_next = S_LOOKUP;
        end
        S_LOOKUP: begin
          if (w_grant[gi]) begin
            if (r_is_write) w_state_next = S_MEM_WRITE;
            else if (w_hit) w_state_next = S_DONE;
            else            w_state_next = S_MEM_READ;
          end
        end
        S_MEM_READ:  if (controller_read_ready[gi])  w_state_next = S_FILL;
        S_FILL:      if (w_grant[gi])                w_state_next = S_DONE;
        S_MEM_WRITE: if (controller_write_ready[gi]) w_state_next = S_DONE;
        S_DONE: begin
          if (r_is_write ? !consumer_write_valid[gi] : !consumer_read_valid[gi])
            w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end

    // Request latches and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_addr     <= '0;
        r_wdata    <= '0;
        r_rdata    <= '0;
        r_is_write <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (consumer_read_valid[gi]) begin
              r_addr     <= consumer_read_address[gi];
              r_is_write <= 1'b0;
            end else if (consumer_write_valid[gi]) begin
              r_addr     <= consumer_write_address[gi];
              r_wdata    <= consumer_write_data[gi];
              r_is_write <= 1'b1;
            end
          end
          S_LOOKUP: begin
            if (w_grant[gi] && !r_is_write && w_hit) r_rdata <= r_data[w_set][w_hit_way];
          end
          S_MEM_READ: begin
            if (controller_read_ready[gi]) r_rdata <= controller_read_data[gi];
          end
          default: ;
        endcase
      end
    end

    // Outputs decode from the state register only; data buses read 0 when idle.
    always_comb begin
      w_rd_ready  = (r_state == S_DONE) && !r_is_write;
      w_wr_ready  = (r_state == S_DONE) && r_is_write;
      w_rd_data   = w_rd_ready ? r_rdata : '0;
      w_ctl_rv    = (r_state == S_MEM_READ);
      w_ctl_raddr = w_ctl_rv ? r_addr : '0;
      w_ctl_wv    = (r_state == S_MEM_WRITE);
      w_ctl_waddr = w_ctl_wv ? r_addr : '0;
      w_ctl_wdata = w_ctl_wv ? r_wdata : '0;
    end

    assign consumer_read_ready[gi]      = w_rd_ready;
    assign consumer_read_data[gi]       = w_rd_data;
    assign consumer_write_ready[gi]     = w_wr_ready;
    assign controller_read_valid[gi]    = w_ctl_rv;
    assign controller_read_address[gi]  = w_ctl_raddr;
    assign controller_write_valid[gi]   = w_ctl_wv;
    assign controller_write_address[gi] = w_ctl_waddr;
    assign controller_write_data[gi]    = w_ctl_wdata;
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] rd_valid = '0, rd_ready, wr_valid = '0, wr_ready;
  logic [NC-1:0] c_rvalid, c_rready = '0, c_wvalid, c_wready = '0;
  logic [7:0]    rd_addr [NC], rd_data [NC], wr_addr [NC], wr_data [NC];
  logic [7:0]    c_raddr [NC], c_rdata [NC], c_waddr [NC], c_wdata [NC];

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
    .consumer_read_ready(rd_ready), .consumer_read_data(rd_data),
    .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
    .consumer_write_data(wr_data), .consumer_write_ready(wr_ready),
    .controller_read_valid(c_rvalid), .controller_read_address(c_raddr),
    .controller_read_ready(c_rready), .controller_read_data(c_rdata),
    .controller_write_valid(c_wvalid), .controller_write_address(c_waddr),
    .controller_write_data(c_wdata), .controller_write_ready(c_wready)
  );

  typedef struct {
    bit         is_wr;
    int         lane;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         exp_fetch;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [7:0] lane;
    logic [7:0] data;
  } rexp_t;

  rexp_t       rq[$];   // expected read completions
  logic [15:0] wq[$];   // expected write-throughs {addr, data}
  logic [7:0]  mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit outputs_quiet();
    bit q = (rd_ready == '0) && (wr_ready == '0) && (c_rvalid == '0) && (c_wvalid == '0);
    for (int l = 0; l < NC; l++)
      q &= (rd_data[l] == 8'h00) && (c_raddr[l] == 8'h00) && (c_waddr[l] == 8'h00) && (c_wdata[l] == 8'h00);
    return q;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc = 0, n_fetch = 0, n_wt = 0;
    bit done = 0, stray = 0;
    logic [7:0] got = 8'h00;
    rexp_t e, r;
    logic [15:0] we;
    if (v.is_wr) begin
      wr_addr[v.lane] = v.addr; wr_data[v.lane] = v.wdata; wr_valid[v.lane] = 1'b1;
      wq.push_back({v.addr, v.wdata});
    end else begin
      rd_addr[v.lane] = v.addr; rd_valid[v.lane] = 1'b1;
      e.lane = 8'(v.lane); e.data = v.exp_data;
      rq.push_back(e);
    end
    while (!done && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      c_rready = '0; c_wready = '0;
      for (int l = 0; l < NC; l++)
        if (l != v.lane && (c_rvalid[l] || c_wvalid[l])) stray = 1;
      if (c_rvalid[v.lane]) begin
        n_fetch++;
        chk("fetch_addr", 32'(c_raddr[v.lane]), 32'(v.addr));
        c_rdata[v.lane] = mem[c_raddr[v.lane]];
        c_rready[v.lane] = 1'b1;
      end
      if (c_wvalid[v.lane]) begin
        n_wt++;
        if (wq.size() == 0) chk("wt_unexpected", 32'(n_wt), 32'(0));
        else begin
          we = wq.pop_front();
          chk("wt_addr", 32'(c_waddr[v.lane]), 32'(we[15:8]));
          chk("wt_data", 32'(c_wdata[v.lane]), 32'(we[7:0]));
        end
        mem[c_waddr[v.lane]] = c_wdata[v.lane];
        c_wready[v.lane] = 1'b1;
      end
      if (v.is_wr ? wr_ready[v.lane] : rd_ready[v.lane]) begin
        done = 1;
        got = rd_data[v.lane];
      end
    end
    chk("ready_seen", 32'(done), 32'(1));
    chk("fetch_count", 32'(n_fetch), v.is_wr ? 32'(0) : 32'(v.exp_fetch));
    chk("wt_count", 32'(n_wt), v.is_wr ? 32'(1) : 32'(0));
    chk("stray_ctrl_valid", 32'(stray), 32'(0));
    if (!v.is_wr) begin
      if (rq.size() == 0) chk("rq_empty", 32'(0), 32'(1));
      else begin
        r = rq.pop_front();
        chk("read_lane", 32'(v.lane), 32'(r.lane));
        chk("read_data", 32'(got), 32'(r.data));
      end
      if (!v.exp_fetch) chk("hit_latency", 32'(cyc), 32'(2));
    end
    // Valid held one more cycle: ready and data must persist.
    @(posedge clk); #1;
    if (v.is_wr) chk("wr_ready_hold", 32'(wr_ready[v.lane]), 32'(1));
    else begin
      chk("rd_ready_hold", 32'(rd_ready[v.lane]), 32'(1));
      chk("rd_data_hold", 32'(rd_data[v.lane]), 32'(got));
    end
    rd_valid[v.lane] = 1'b0; wr_valid[v.lane] = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", 32'(rd_ready[v.lane] | wr_ready[v.lane]), 32'(0));
    $display("txn %s lane=%0d addr=0x%0h data=0x%0h fetches=%0d cycles=%0d",
             v.is_wr ? "WR" : "RD", v.lane, v.addr, v.is_wr ? v.wdata : got, n_fetch, cyc);
  endtask

  vec_t vecs [14];

  initial begin
    int t0, t3, cyc;
    bit seen;
    rexp_t e, r;
    vec_t v;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h12] = 8'hAB;
    for (int l = 0; l < NC; l++) begin
      rd_addr[l] = '0; wr_addr[l] = '0; wr_data[l] = '0; c_rdata[l] = '0;
    end
    //          is_wr lane addr   wdata  fetch data
    vecs[0]  = '{0, 0, 8'h12, 8'h00, 1, 8'hAB};  // cold miss
    vecs[1]  = '{0, 0, 8'h12, 8'h00, 0, 8'hAB};  // re-read hit
    vecs[2]  = '{1, 1, 8'h12, 8'h5C, 0, 8'h00};  // write hit
    vecs[3]  = '{0, 2, 8'h12, 8'h00, 0, 8'h5C};  // other lane sees new data
    vecs[4]  = '{1, 4, 8'h33, 8'h77, 0, 8'h00};  // write miss, no allocate
    vecs[5]  = '{0, 4, 8'h33, 8'h00, 1, 8'h77};  // so the read still misses
    vecs[6]  = '{0, 5, 8'h33, 8'h00, 0, 8'h77};
    vecs[7]  = '{0, 0, 8'h20, 8'h00, 1, 8'h1C};  // fill set 0
    vecs[8]  = '{0, 1, 8'h40, 8'h00, 1, 8'h7C};
    vecs[9]  = '{0, 2, 8'h60, 8'h00, 1, 8'h5C};
    vecs[10] = '{0, 3, 8'h80, 8'h00, 1, 8'hBC};  // 5th tag evicts way0 (0x12)
    vecs[11] = '{0, 6, 8'h12, 8'h00, 1, 8'h5C};  // evicted line misses again
    vecs[12] = '{0, 7, 8'h40, 8'h00, 0, 8'h7C};
    vecs[13] = '{0, 0, 8'h80, 8'h00, 0, 8'hBC};

    // Reset and idle behaviour.
    repeat (2) @(posedge clk);
    #1 chk("reset_quiet", 32'(outputs_quiet()), 32'(1));
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("idle_quiet", 32'(outputs_quiet()), 32'(1));
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Same-bank contention: lanes 0 and 3 both hit set 0 in the same cycle.
    rd_addr[0] = 8'h40; rd_addr[3] = 8'h80;
    rd_valid[0] = 1'b1; rd_valid[3] = 1'b1;
    e.lane = 8'd0; e.data = 8'h7C; rq.push_back(e);
    e.lane = 8'd3; e.data = 8'hBC; rq.push_back(e);
    t0 = 0; t3 = 0; cyc = 0;
    while ((t0 == 0 || t3 == 0) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      chk("contend_no_ctrl", 32'(c_rvalid | c_wvalid), 32'(0));
      for (int l = 0; l < NC; l += 3) begin
        if (rd_ready[l] && ((l == 0 && t0 == 0) || (l == 3 && t3 == 0))) begin
          if (l == 0) t0 = cyc; else t3 = cyc;
          r = rq.pop_front();
          chk("contend_order", 32'(l), 32'(r.lane));
          chk("contend_data", 32'(rd_data[l]), 32'(r.data));
        end
      end
    end
    chk("contend_lane0_cycle", 32'(t0), 32'(2));
    chk("contend_lane3_cycle", 32'(t3), 32'(3));
    $display("txn CONTEND lane0 ready at %0d, lane3 ready at %0d", t0, t3);
    rd_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a miss is outstanding.
    rd_addr[0] = 8'h02; rd_valid[0] = 1'b1;
    seen = 0; cyc = 0;
    while (!seen && cyc < 10) begin
      @(posedge clk); #1; cyc++;
      seen = c_rvalid[0];
    end
    chk("miss_pending", 32'(seen), 32'(1));
    #2 reset = 1'b0;
    #1 chk("async_reset_quiet", 32'(outputs_quiet()), 32'(1));
    rd_valid = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_hold_quiet", 32'(outputs_quiet()), 32'(1));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    $display("txn RESET during miss on lane0 addr=0x02");
    // Valid bits were cleared, so a previously resident line must miss.
    v = '{0, 0, 8'h40, 8'h00, 1, 8'h7C};
    run_vec(v);

    chk("rq_drained", 32'(rq.size()), 32'(0));
    chk("wq_drained", 32'(wq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
